muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Multi-cycle sequencer for the RV32M multiply/divide operations in the execute stage. It accepts one M-extension operation from EX and latches its operands. It runs a registered multiply or a radix-2 restoring divide, and holds the pipeline stall until the result is ready. The ALU keeps base-ISA work; EX selects this block's result for instructions with the M-extension funct7 (0000001).

## Interface
- XLEN, 32: operand/result width; divide iteration count equals XLEN.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  EX holds a valid M-op; sampled only in IDLE.
- func3_i  in  3  M-op select: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (000..111).
- rs1_i  in  XLEN  dividend / multiplicand.
- rs2_i  in  XLEN  divisor / multiplier.
- flush_i  in  1  EX squash (branch/trap); aborts any operation.
- stall_o  out  1  freezes IF/ID/EX while an operation is pending.
- busy_o  out  1  state is not IDLE.
- valid_o  out  1  one-cycle pulse, result_o valid.
- result_o  out  XLEN  registered result, held until the next accepted start.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE + start_i + !flush_i: latch func3, rs1 and rs2, plus sign flags per func3.
  - MULx goes to MUL.
  - Divide-class with divisor 0, or signed overflow (0x80000000 / -1), goes to DONE directly (fast path).
  - Other divide-class ops go to DIV.
- MUL:
  - Register the 33x33 signed product of sign/zero-extended operands. MULHSU sign-extends rs1 only.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
  - Next state DONE.
- DIV:
  - Divides the magnitudes, |rs1| by |rs2| for signed ops and raw values for unsigned.
  - Each cycle: shift {rem,quot} left 1 and trial-subtract the divisor. If rem ≥ 0, set the quotient LSB; otherwise restore rem.
  - 5-bit counter; after XLEN iterations go to FIX.
- FIX:
  - Negate the quotient if the operand signs differ (DIV).
  - Negate the remainder if the dividend is negative (REM).
  - Next state DONE.
- Fast-path results:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Overflow: DIV gives 0x80000000; REM gives 0.
- DONE: valid_o=1, stall_o=0, result_o stable; next state IDLE unconditionally. start_i is ignored in DONE because EX still holds the finishing op.
- flush_i high in any state: next state IDLE, no valid_o, result_o unchanged. flush_i takes priority over start_i.
- Reset values: state IDLE; stall_o, busy_o and valid_o 0; result_o 0; counter 0.

## Timing
- stall_o is combinational: (state ∈ {MUL, DIV, FIX}) or (state==IDLE and start_i and !flush_i). The stall rises in the start cycle T itself.
- Latency from acceptance at edge T, to the valid_o cycle:
  - Multiply: T+2.
  - Fast-path divide: T+1.
  - Normal divide: T+XLEN+2 = T+34.
- Back-to-back M-ops: a new start is accepted in the IDLE cycle after DONE, so throughput is one op per latency+1 cycles.
- Reset asserted mid-operation: immediately IDLE with outputs at reset values. No valid_o after release.
- A flush in the DONE cycle suppresses nothing further; valid_o has already been issued combinationally from state.

## Structure
- Shared defines: FUNC7_MULDIV, the eight MD_* func3 codes, and state encodings. These go beside the existing OPCODE_/ALU_ constants.
- One sub-module: div_radix2_step, a combinational single restoring iteration. Inputs: rem, quot, divisor. Outputs: next rem, next quot.
- Multiplier product register and FSM stay in muldiv_sequencer.

## Test plan
- MUL, rs1=7, rs2=0xFFFFFFFD (−3) -> result 0xFFFFFFEB, valid_o at T+2, stall_o high at T and T+1.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULH of the same operands -> 0x00000000; MULHSU(−1, 0xFFFFFFFF) -> 0xFFFFFFFF.
- DIV −7/2 -> 0xFFFFFFFD, REM −7/2 -> 0xFFFFFFFF, DIVU 100/7 -> 14; each valid_o at T+34.
- DIVU x/0 -> 0xFFFFFFFF and REMU 0x1234/0 -> 0x1234, both at T+1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Flush at T+10 of a DIV -> busy_o low at T+11, no valid_o. A new MUL started at T+11 -> correct result at T+13.
- rst_n pulsed low mid-DIV -> state IDLE and outputs at reset values immediately. The first start after release completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// This package holds the funct7/func3 decode constants and the FSM state encoding.
package muldiv_pkg;

    localparam int MD_XLEN = 32;

    localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_t;

endpackage

// File: rtl/div_radix2_step.sv
// One restoring-division iteration. The block shifts {rem,quot} left by one and trial-subtracts the divisor.
// It operates on magnitudes only.
module div_radix2_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quot_next
);

    logic [XLEN:0] shifted_s;
    logic [XLEN:0] trial_s;

    // Trial subtract; the extra MSB is the borrow that signals a negative remainder
    always_comb begin
        shifted_s = {rem, quot[XLEN-1]};
        trial_s   = shifted_s - {1'b0, divisor};
        if (!trial_s[XLEN]) begin
            rem_next  = trial_s[XLEN-1:0];
            quot_next = {quot[XLEN-2:0], 1'b1};
        end else begin
            rem_next  = shifted_s[XLEN-1:0];
            quot_next = {quot[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M execute unit. It performs a single-cycle registered multiply or a radix-2 restoring divide.
// It stalls the front of the pipeline until the result is ready.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    md_state_t       state_r, state_s;
    logic [2:0]      func3_r;
    logic [XLEN-1:0] op_a_r, op_b_r, rem_r, quot_r, result_r;
    logic            a_neg_r, b_neg_r;
    logic [CW-1:0]   cnt_r;

    logic            accept_s, is_mul_s, a_sig_s, b_sig_s, a_neg_s, b_neg_s;
    logic            div_zero_s, div_ovf_s;
    logic [XLEN-1:0] fast_res_s, mul_res_s, fix_res_s, rem_nxt_s, quot_nxt_s;
    logic [2*XLEN-1:0] prod_s;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? ({XLEN{1'b0}} - v) : v;
    endfunction

    // Decode of an incoming op: signedness per operand, fast-path detection and fast-path result
    always_comb begin
        accept_s   = (state_r == ST_IDLE) && start_i && !flush_i;
        is_mul_s   = ~func3_i[2];
        a_sig_s    = func3_i[2] ? ~func3_i[0] : (func3_i[1:0] != 2'b11);
        b_sig_s    = func3_i[2] ? ~func3_i[0] : ~func3_i[1];
        a_neg_s    = a_sig_s & rs1_i[XLEN-1];
        b_neg_s    = b_sig_s & rs2_i[XLEN-1];
        div_zero_s = (rs2_i == {XLEN{1'b0}});
        div_ovf_s  = ~func3_i[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == {XLEN{1'b1}});
        if (div_zero_s) begin
            fast_res_s = func3_i[1] ? rs1_i : {XLEN{1'b1}};
        end else begin
            fast_res_s = func3_i[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // The sign flags equal the 33rd-bit extension, so a 2*XLEN wrap-around multiply yields the exact 33x33 product bits
    always_comb begin
        prod_s    = {{XLEN{a_neg_r}}, op_a_r} * {{XLEN{b_neg_r}}, op_b_r};
        mul_res_s = (func3_r == MD_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        fix_res_s = func3_r[1] ? cond_neg(rem_r, a_neg_r) : cond_neg(quot_r, a_neg_r ^ b_neg_r);
    end

    div_radix2_step #(.XLEN(XLEN)) u_step (
        .rem       (rem_r),
        .quot      (quot_r),
        .divisor   (op_b_r),
        .rem_next  (rem_nxt_s),
        .quot_next (quot_nxt_s)
    );

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_s = ST_IDLE;
                end else if (is_mul_s) begin
                    state_s = ST_MUL;
                end else if (div_zero_s || div_ovf_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DIV;
                end
            end
            ST_MUL:  state_s = ST_DONE;
            ST_DIV:  state_s = (cnt_r == CNT_LAST) ? ST_FIX : ST_DIV;
            ST_FIX:  state_s = ST_DONE;
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
        if (flush_i) begin
            state_s = ST_IDLE;
        end else begin
            state_s = state_s;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, divide iteration and result register; a flushed op leaves the result untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func3_r  <= 3'b000;
            op_a_r   <= {XLEN{1'b0}};
            op_b_r   <= {XLEN{1'b0}};
            rem_r    <= {XLEN{1'b0}};
            quot_r   <= {XLEN{1'b0}};
            a_neg_r  <= 1'b0;
            b_neg_r  <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            result_r <= {XLEN{1'b0}};
        end else if (accept_s) begin
            func3_r <= func3_i;
            a_neg_r <= a_neg_s;
            b_neg_r <= b_neg_s;
            cnt_r   <= {CW{1'b0}};
            rem_r   <= {XLEN{1'b0}};
            op_a_r  <= rs1_i;
            op_b_r  <= is_mul_s ? rs2_i : cond_neg(rs2_i, b_neg_s);
            quot_r  <= cond_neg(rs1_i, a_neg_s);
            if (!is_mul_s && (div_zero_s || div_ovf_s)) begin
                result_r <= fast_res_s;
            end
        end else if (!flush_i) begin
            case (state_r)
                ST_MUL: result_r <= mul_res_s;
                ST_DIV: begin
                    rem_r  <= rem_nxt_s;
                    quot_r <= quot_nxt_s;
                    cnt_r  <= cnt_r + CW'(1);
                end
                ST_FIX:  result_r <= fix_res_s;
                default: result_r <= result_r;
            endcase
        end
    end

    assign stall_o  = (state_r == ST_MUL) || (state_r == ST_DIV) || (state_r == ST_FIX) || accept_s;
    assign busy_o   = (state_r != ST_IDLE);
    assign valid_o  = (state_r == ST_DONE);
    assign result_o = result_r;

endmodule
